// File: rtl/sdf_commutator_sync_low_reset.sv
// Single-path delay-feedback commutator: buffers the first half of each 2*DEPTH frame and
// emits (x[k], x[k+DEPTH]) butterfly pairs while the second half streams in.
module sdf_commutator_sync_low_reset #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_a,
  output logic [DATA_WIDTH-1:0]      out_b,
  output logic [$clog2(DEPTH)-1:0]   out_k,
  output logic                       out_sel,
  output logic                       frame_done
);

  localparam int unsigned KW = $clog2(DEPTH);
  localparam int unsigned CW = KW + 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [KW-1:0]         addr;
  logic                  second_half;

  logic                  out_valid_d, out_sel_d, frame_done_d;
  logic [DATA_WIDTH-1:0] out_a_d, out_b_d;
  logic [KW-1:0]         out_k_d;

  assign in_ready    = ~hold;
  assign addr        = cnt_q[KW-1:0];
  assign second_half = cnt_q[CW-1];

  always_comb begin
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    out_a_d      = out_a;
    out_b_d      = out_b;
    out_k_d      = out_k;
    out_sel_d    = out_sel;
    if (in_valid) begin
      cnt_d     = cnt_q + CW'(1);
      out_sel_d = second_half;
      if (second_half) begin
        out_valid_d  = 1'b1;
        out_a_d      = mem_q[addr];
        out_b_d      = in_data;
        out_k_d      = addr;
        // DEPTH is a power of two, so all-ones marks the last sample of the frame
        frame_done_d = &cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_k      <= '0;
      out_sel    <= 1'b0;
      frame_done <= 1'b0;
    end else if (!hold) begin
      cnt_q      <= cnt_d;
      out_valid  <= out_valid_d;
      out_a      <= out_a_d;
      out_b      <= out_b_d;
      out_k      <= out_k_d;
      out_sel    <= out_sel_d;
      frame_done <= frame_done_d;
    end
  end

  // Buffer is not reset; every entry is rewritten before it is read in a new frame.
  always_ff @(posedge clk) begin
    if (rst && !hold && in_valid && !second_half) begin
      mem_q[addr] <= in_data;
    end
  end

endmodule

// File: tb/tb_sdf_commutator_sync_low_reset.sv
// Scoreboard bench for the SDF commutator: driver pushes expected pairs, monitor pops and checks.
module tb_sdf_commutator_sync_low_reset;

  localparam int unsigned DW = 16;
  localparam int unsigned D  = 32;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [4:0]    k;
    logic          fd;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hold = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_sel, frame_done;
  logic [DW-1:0] out_a, out_b;
  logic [4:0]    out_k;

  int n_tests = 0;
  int n_fail  = 0;
  pair_t exp_q[$];
  logic [5:0] cnt_m = '0;

  sdf_commutator_sync_low_reset #(
    .DATA_WIDTH(DW),
    .DEPTH     (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_k     (out_k),
    .out_sel   (out_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Data equals frame index (+64*n), so the hand-computed pair is (v-32, v) with k = v mod 32.
  task automatic send(input logic [DW-1:0] v);
    pair_t e;
    logic  sel_exp;
    in_valid = 1'b1;
    in_data  = v;
    hold     = 1'b0;
    sel_exp  = cnt_m[5];
    if (cnt_m[5]) begin
      e.a  = v - 16'd32;
      e.b  = v;
      e.k  = v[4:0];
      e.fd = (v[5:0] == 6'd63);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cnt_m = cnt_m + 6'd1;
    check("out_sel", {63'd0, out_sel}, {63'd0, sel_exp});
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic with_hold);
    rst      = 1'b0;
    hold     = with_hold;
    in_valid = 1'b1;
    in_data  = 16'hdead;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    hold  = 1'b0;
    cnt_m = '0;
  endtask

  // Monitor
  initial begin
    logic  r_e, h_e, iv_e, v_now;
    pair_t last, e;
    last  = '0;
    v_now = 1'b0;
    forever begin
      @(posedge clk);
      r_e  = rst;
      h_e  = hold;
      iv_e = in_valid;
      @(negedge clk);
      if (!r_e) begin
        check("reset_outputs", {25'd0, out_valid, out_a, out_b, out_k, out_sel, frame_done},
              64'd0);
        last  = '0;
        v_now = 1'b0;
      end else if (h_e) begin
        check("hold_frozen", {25'd0, out_valid, out_a, out_b, out_k, frame_done},
              {25'd0, v_now, last.a, last.b, last.k, last.fd & v_now});
      end else if (!iv_e || !out_valid) begin
        check("no_pair", {25'd0, out_valid, out_a, out_b, out_k, frame_done},
              {25'd0, 1'b0, last.a, last.b, last.k, 1'b0});
        v_now = 1'b0;
      end else if (exp_q.size() == 0) begin
        check("spurious_pair", {63'd0, out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pair", {25'd0, out_a, out_b, out_k, frame_done},
              {25'd0, e.a, e.b, e.k, e.fd});
        last  = e;
        v_now = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);

    // Two back-to-back frames
    for (int v = 0; v < 128; v++) send(DW'(v));

    // Hold for three cycles after sample 40, upstream keeps sample 41 stable
    for (int v = 0; v <= 40; v++) send(DW'(v));
    in_valid = 1'b1;
    in_data  = 16'd41;
    hold     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("in_ready_hold", {63'd0, in_ready}, 64'd0);
    for (int v = 41; v < 64; v++) send(DW'(v));

    // Gap on every other cycle
    for (int v = 0; v < 64; v++) begin
      send(DW'(v));
      idle();
    end

    // Reset mid-frame, then a clean frame
    for (int v = 0; v <= 45; v++) send(DW'(v));
    do_reset(1'b0);
    for (int v = 0; v < 64; v++) send(DW'(v));

    // Reset while hold is asserted still takes effect
    for (int v = 0; v <= 35; v++) send(DW'(v));
    do_reset(1'b1);
    for (int v = 0; v < 64; v++) send(DW'(v));

    idle();
    idle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
